shared_sram_arbiter: RTL and testbench

//  Arbitrates one single-port SRAM macro (64x8 by default) between three requesters:
//  the Wishbone host (index 0), qcpu (index 1) and mc14500 (index 2).

---
 rtl/shared_sram_arbiter.sv | 101 ++++++++++
 tb/tb_shared_sram_arbiter.sv | 194 +++++++++++++++++++
 2 files changed

// File: rtl/shared_sram_arbiter.sv
// Three-way arbiter for one single-port SRAM: Wishbone (0) has fixed priority,
// the two cores (1, 2) alternate round-robin. Each access is IDLE -> ACCESS -> RESP.
module shared_sram_arbiter #(
  parameter int ADDR_W = 6,
  parameter int DATA_W = 8
) (
  input  logic                  wb_clk_i,
  input  logic                  wb_rst_i,
  input  logic [2:0]            en_i,
  input  logic [2:0]            req_i,
  input  logic [2:0]            we_i,
  input  logic [3*ADDR_W-1:0]   addr_i,
  input  logic [3*DATA_W-1:0]   wdata_i,
  output logic [2:0]            ack_o,
  output logic [DATA_W-1:0]     rdata_o,
  output logic                  busy_o,
  output logic [1:0]            owner_o,
  output logic [ADDR_W-1:0]     sram_addr,
  output logic [DATA_W-1:0]     sram_din,
  output logic                  sram_cen,
  output logic                  sram_gwe,
  input  logic [DATA_W-1:0]     sram_dout
);
  localparam int NUM_REQ = 3;

  localparam logic [1:0] S_IDLE   = 2'd0;
  localparam logic [1:0] S_ACCESS = 2'd1;
  localparam logic [1:0] S_RESP   = 2'd2;

  typedef struct packed {
    logic [1:0]        owner;
    logic              we;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] wdata;
  } acc_t;

  logic [1:0]                       state;
  acc_t                             acc_q;
  logic                             rr_q;    // 1 = core 2 favoured next
  logic [DATA_W-1:0]                hold_q;
  logic [NUM_REQ-1:0][ADDR_W-1:0]   addr_v;
  logic [NUM_REQ-1:0][DATA_W-1:0]   wdata_v;
  logic [NUM_REQ-1:0]               elig;
  logic [1:0]                       win;

  for (genvar g = 0; g < NUM_REQ; g++) begin : g_unpack
    assign addr_v[g]  = addr_i[g*ADDR_W +: ADDR_W];
    assign wdata_v[g] = wdata_i[g*DATA_W +: DATA_W];
  end

  assign elig = req_i & en_i;

  // Wishbone first, then the favoured core, then the other core.
  always_comb begin
    win = 2'd0;
    if (elig[0])                         win = 2'd0;
    else if (rr_q ? elig[2] : elig[1])   win = rr_q ? 2'd2 : 2'd1;
    else if (elig[1])                    win = 2'd1;
    else if (elig[2])                    win = 2'd2;
  end

  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      state  <= S_IDLE;
      acc_q  <= '0;
      rr_q   <= 1'b0;
      hold_q <= '0;
    end else begin
      case (state)
        S_IDLE: if (|elig) begin
          acc_q.owner <= win;
          acc_q.we    <= we_i[win];
          acc_q.addr  <= addr_v[win];
          acc_q.wdata <= wdata_v[win];
          state       <= S_ACCESS;
        end
        S_ACCESS: state <= S_RESP;
        S_RESP: begin
          hold_q <= sram_dout;
          if (acc_q.owner != 2'd0) rr_q <= (acc_q.owner == 2'd1);
          state <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  always_comb begin
    ack_o = '0;
    if (state == S_RESP) ack_o[acc_q.owner] = 1'b1;
  end

  assign rdata_o   = (state == S_RESP) ? sram_dout : hold_q;
  assign busy_o    = (state != S_IDLE);
  assign owner_o   = acc_q.owner;
  assign sram_addr = acc_q.addr;
  assign sram_din  = acc_q.wdata;
  assign sram_cen  = (state != S_ACCESS);
  assign sram_gwe  = ~((state == S_ACCESS) & acc_q.we);

endmodule

// File: tb/tb_shared_sram_arbiter.sv
// Randomized bench for shared_sram_arbiter: three requester agents, an SRAM
// model, and a transaction-level reference of grants, acks and memory contents.
module tb_shared_sram_arbiter;
  localparam int AW = 6;
  localparam int DW = 8;

  logic            clk = 1'b0;
  logic            rst = 1'b1;
  logic [2:0]      en = 3'b111, req = '0, we = '0;
  logic [3*AW-1:0] addr = '0;
  logic [3*DW-1:0] wdata = '0;
  logic [2:0]      ack_o;
  logic [DW-1:0]   rdata_o;
  logic            busy_o;
  logic [1:0]      owner_o;
  logic [AW-1:0]   sram_addr;
  logic [DW-1:0]   sram_din;
  logic            sram_cen, sram_gwe;
  logic [DW-1:0]   sram_dout = '0;

  shared_sram_arbiter #(.ADDR_W(AW), .DATA_W(DW)) dut (
    .wb_clk_i(clk), .wb_rst_i(rst), .en_i(en), .req_i(req), .we_i(we),
    .addr_i(addr), .wdata_i(wdata), .ack_o(ack_o), .rdata_o(rdata_o),
    .busy_o(busy_o), .owner_o(owner_o), .sram_addr(sram_addr), .sram_din(sram_din),
    .sram_cen(sram_cen), .sram_gwe(sram_gwe), .sram_dout(sram_dout)
  );

  always #5 clk = ~clk;

  // SRAM macro model: read data appears the cycle after the enabled edge
  logic [DW-1:0] mem [64];
  always @(posedge clk)
    if (!sram_cen) begin
      if (!sram_gwe) mem[sram_addr] <= sram_din;
      else           sram_dout      <= mem[sram_addr];
    end

  int n_chk = 0, n_fail = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Reference: cycles since grant (0 = no access, 1 = memory cycle, 2 = ack cycle)
  logic [DW-1:0] refmem [64];
  int            m_age = 0, m_owner = 0;
  logic          m_we = 1'b0;
  logic [AW-1:0] m_addr = '0;
  logic [DW-1:0] m_wdata = '0;
  bit            m_pref2 = 1'b0;
  logic [DW-1:0] m_hold = '0;
  bit            m_hold_ok = 1'b1;
  bit            m_fresh = 1'b1;

  // Requester agents
  logic [2:0]    pend = '0;
  logic          r_we   [3];
  logic [AW-1:0] r_addr [3];
  logic [DW-1:0] r_data [3];

  function automatic bit want(input int mode, input int r);
    case (mode)
      0:       return $urandom_range(0, 3) == 0;
      1:       return 1'b1;
      2:       return r != 0;
      3:       return r == 2;
      default: return 1'b0;
    endcase
  endfunction

  // mode: 0 random, 1 all request, 2 cores only, 3 core2 masked, 4 no new requests
  task automatic step(input int mode, input bit do_rst);
    logic [2:0] exp_ack, elig;
    int w;
    @(negedge clk);
    exp_ack = (m_age == 2) ? 3'(1 << m_owner) : 3'b000;
    chk("ack", ack_o, exp_ack);
    chk("busy", busy_o, m_age != 0);
    chk("cen", sram_cen, m_age != 1);
    chk("gwe", sram_gwe, !(m_age == 1 && m_we));
    chk("owner", owner_o, m_owner);
    if (m_age == 1) begin
      chk("sram_addr", sram_addr, m_addr);
      if (m_we) chk("sram_din", sram_din, m_wdata);
    end
    if (m_age == 2 && !m_we) chk("rdata", rdata_o, refmem[m_addr]);
    if (m_age == 0 && m_hold_ok) chk("hold", rdata_o, m_hold);
    if (m_fresh) begin
      chk("rst_addr", sram_addr, 0);
      chk("rst_din", sram_din, 0);
      m_fresh = 1'b0;
    end

    pend = pend & ~exp_ack;
    rst  = do_rst;
    if (do_rst) pend = '0;
    else
      for (int r = 0; r < 3; r++)
        if (!pend[r] && want(mode, r)) begin
          pend[r]   = 1'b1;
          r_we[r]   = 1'($urandom);
          r_addr[r] = AW'($urandom);
          r_data[r] = DW'($urandom);
        end
    case (mode)
      0:       en = ($urandom_range(0, 4) == 0) ? 3'($urandom) : 3'b111;
      3:       en = 3'b011;
      default: en = 3'b111;
    endcase
    req = pend;
    for (int r = 0; r < 3; r++) begin
      we[r]             = r_we[r];
      addr[r*AW +: AW]  = r_addr[r];
      wdata[r*DW +: DW] = r_data[r];
    end

    // Advance reference across the coming edge
    if (do_rst) begin
      if (m_age == 1 && m_we) refmem[m_addr] = m_wdata;
      m_age = 0; m_owner = 0; m_pref2 = 1'b0; m_we = 1'b0;
      m_addr = '0; m_wdata = '0; m_hold = '0; m_hold_ok = 1'b1; m_fresh = 1'b1;
    end else if (m_age == 0) begin
      elig = req & en;
      if (elig != 0) begin
        if (elig[0])                        w = 0;
        else if (m_pref2 ? elig[2] : elig[1]) w = m_pref2 ? 2 : 1;
        else                                w = elig[1] ? 1 : 2;
        m_owner = w; m_we = r_we[w]; m_addr = r_addr[w]; m_wdata = r_data[w];
        m_age = 1;
      end
    end else if (m_age == 1) begin
      if (m_we) refmem[m_addr] = m_wdata;
      m_age = 2;
    end else begin
      m_hold_ok = !m_we;
      if (!m_we) m_hold = refmem[m_addr];
      if (m_owner != 0) m_pref2 = (m_owner == 1);
      m_age = 0;
    end
  endtask

  task automatic issue(input int r, input logic w, input logic [AW-1:0] a, input logic [DW-1:0] d);
    pend[r] = 1'b1; r_we[r] = w; r_addr[r] = a; r_data[r] = d;
    repeat (3) step(4, 1'b0);
  endtask

  initial begin
    bit found;
    for (int i = 0; i < 64; i++) begin
      mem[i]    = DW'($urandom);
      refmem[i] = mem[i];
    end
    repeat (2) step(4, 1'b1);
    step(4, 1'b0);

    // Single read of a preloaded word, then write/read at the top address
    mem[5] = 8'hA5; refmem[5] = 8'hA5;
    issue(1, 1'b0, 6'd5, 8'h00);
    issue(2, 1'b1, 6'd63, 8'h3C);
    issue(2, 1'b0, 6'd63, 8'h00);
    chk("readback_63", m_hold, 8'h3C);

    repeat (300) step(0, 1'b0);
    repeat (30)  step(1, 1'b0);
    repeat (30)  step(2, 1'b0);
    repeat (10)  step(4, 1'b0);
    repeat (20)  step(3, 1'b0);
    repeat (5)   step(4, 1'b0);

    // Reset while the memory cycle is in progress
    found = 1'b0;
    for (int i = 0; i < 200 && !found; i++) begin
      step(0, 1'b0);
      found = (m_age == 1);
    end
    chk("found_access", found, 1'b1);
    step(0, 1'b1);
    step(4, 1'b0);
    mem[9] = 8'h5A; refmem[9] = 8'h5A;
    issue(1, 1'b0, 6'd9, 8'h00);
    chk("post_rst_read", m_hold, 8'h5A);

    repeat (400) step(0, 1'b0);
    repeat (5)   step(4, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
